uart_rx_fifo_ctrl: RTL and testbench

Receive-side controller between the UART receiver and the 4-entry RX FIFO. It gates received bytes into the FIFO and tracks occupancy. It sequences host read requests against the FIFO's one-cycle registered read port, and raises sticky overrun and frame-error status, a level-threshold interrupt and an idle character-timeout interrupt. It is the only reader and writer of the FIFO instance it controls.

---
 rtl/uart_rx_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl
// Purpose  : Gates UART RX bytes into a 4-entry FIFO, sequences host reads
//            against its registered read port, and raises status/interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_ctrl #(
    parameter int DEPTH          = 4,
    parameter int THRESH         = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_frame_err,
    output logic                             fifo_wr_en,
    output logic [7:0]                       fifo_wr_data,
    output logic                             fifo_rd_en,
    input  logic [7:0]                       fifo_rd_data,
    input  logic                             fifo_empty,
    input  logic                             fifo_full,
    input  logic                             host_rd_req,
    output logic                             host_rd_valid,
    output logic [7:0]                       host_rd_data,
    output logic                             host_rd_err,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic                             overrun,
    output logic                             frame_err,
    output logic                             timeout,
    input  logic                             clr_status,
    output logic                             irq
);

    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [c_LVL_W-1:0] c_THRESH = c_LVL_W'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_READ       = 2'd1,
        S_CAPTURE    = 2'd2,
        S_EMPTY_RESP = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_rd_en;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_TO_W-1:0]    r_tcnt;
    logic                 r_rd_valid;
    logic [7:0]           r_rd_data;
    logic                 r_rd_err;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 w_set_ovr;
    logic                 w_set_ferr;
    logic                 w_tcnt_clr;

    assign fifo_wr_en   = rx_valid & ~rx_frame_err & ~fifo_full;
    assign fifo_wr_data = rx_data;
    assign fifo_rd_en   = w_rd_en;

    // Overrun is judged on the pre-edge full flag, so a same-cycle read does not rescue the byte
    assign w_set_ovr  = rx_valid & ~rx_frame_err & fifo_full;
    assign w_set_ferr = rx_valid & rx_frame_err;
    assign w_tcnt_clr = (r_level == '0) | rx_valid | w_rd_en | clr_status;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host_rd_req) begin
                    w_state_nxt = fifo_empty ? S_EMPTY_RESP : S_READ;
                end
            end
            S_READ: begin
                w_rd_en     = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE:    w_state_nxt = S_IDLE;
            S_EMPTY_RESP: w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_level     <= '0;
            r_tcnt      <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 8'h00;
            r_rd_err    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= (r_state == S_CAPTURE) | (r_state == S_EMPTY_RESP);
            if (r_state == S_CAPTURE) begin
                r_rd_data <= fifo_rd_data;
                r_rd_err  <= 1'b0;
            end else if (r_state == S_EMPTY_RESP) begin
                r_rd_data <= 8'h00;
                r_rd_err  <= 1'b1;
            end

            case ({fifo_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase

            if (w_tcnt_clr) begin
                r_tcnt <= '0;
            end else if (r_tcnt != c_TO_MAX) begin
                r_tcnt <= r_tcnt + c_TO_W'(1);
            end

            r_overrun   <= w_set_ovr  | (r_overrun   & ~clr_status);
            r_frame_err <= w_set_ferr | (r_frame_err & ~clr_status);
        end
    end

    assign host_rd_valid = r_rd_valid;
    assign host_rd_data  = r_rd_data;
    assign host_rd_err   = r_rd_err;
    assign level         = r_level;
    assign overrun       = r_overrun;
    assign frame_err     = r_frame_err;
    assign timeout       = (r_tcnt == c_TO_MAX);
    assign irq           = (r_level >= c_THRESH) | timeout | r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo_ctrl
// Purpose  : Directed plus random bench for uart_rx_fifo_ctrl against a
//            timeline-based reference model and a queue-backed FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH  = 4;
    localparam int THRESH = 2;
    localparam int TO     = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_frame_err = 1'b0;
    logic       host_rd_req = 1'b0;
    logic       clr_status = 1'b0;
    logic       fifo_wr_en, fifo_rd_en;
    logic [7:0] fifo_wr_data;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty, fifo_full;
    logic       host_rd_valid, host_rd_err;
    logic [7:0] host_rd_data;
    logic [2:0] level;
    logic       overrun, frame_err, timeout, irq;

    uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .THRESH(THRESH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .host_rd_req(host_rd_req), .host_rd_valid(host_rd_valid),
        .host_rd_data(host_rd_data), .host_rd_err(host_rd_err),
        .level(level), .overrun(overrun), .frame_err(frame_err),
        .timeout(timeout), .clr_status(clr_status), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO the controller drives; reset by the same rst_n
    logic [7:0] fq[$];
    int         fcnt = 0;
    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = (fcnt >= DEPTH);

    always @(posedge clk) begin
        if (!rst_n) begin
            fq.delete();
            fcnt <= 0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
            if (fifo_wr_en) fq.push_back(fifo_wr_data);
            fcnt <= fcnt + int'(fifo_wr_en) - int'(fifo_rd_en);
        end
    end

    // Reference model: cycle-numbered timeline of read events plus spec counters
    int         cyc = 0;
    int         m_level = 0, m_tc = 0;
    int         next_accept = 0, rd_cyc = -1, resp_cyc = -1;
    bit         m_ovr = 0, m_fe = 0, m_err = 0, pend_err = 0;
    logic [7:0] m_data = 8'h00, pend_data = 8'h00;
    logic [7:0] exp_q[$];
    int         errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        bit wr, rd, fullb;
        int lvl0;
        @(negedge clk);
        lvl0  = m_level;
        fullb = (m_level == DEPTH);
        if (!rst_n) begin
            m_level = 0; m_tc = 0; m_ovr = 0; m_fe = 0;
            m_data = 8'h00; m_err = 0;
            exp_q.delete();
            rd_cyc = -1; resp_cyc = -1; next_accept = cyc + 1;
        end else begin
            wr = rx_valid && !rx_frame_err && !fullb;
            if (cyc >= next_accept && host_rd_req) begin
                if (m_level > 0) begin
                    rd_cyc = cyc + 1; resp_cyc = cyc + 3; next_accept = cyc + 3;
                    pend_err = 0;
                end else begin
                    resp_cyc = cyc + 2; next_accept = cyc + 2;
                    pend_err = 1; pend_data = 8'h00;
                end
            end
            rd = (cyc == rd_cyc);
            chk("fifo_wr_en", fifo_wr_en, wr);
            chk("fifo_rd_en", fifo_rd_en, rd);
            if (wr) chk("fifo_wr_data", fifo_wr_data, rx_data);
            if (rd) pend_data = exp_q.pop_front();
            if (wr) exp_q.push_back(rx_data);
            m_level = m_level + int'(wr) - int'(rd);
            if (lvl0 == 0 || rx_valid || rd || clr_status) m_tc = 0;
            else if (m_tc < TO) m_tc = m_tc + 1;
            m_ovr = (rx_valid && !rx_frame_err && fullb) || (m_ovr && !clr_status);
            m_fe  = (rx_valid && rx_frame_err) || (m_fe && !clr_status);
            if (cyc + 1 == resp_cyc) begin
                m_data = pend_data;
                m_err  = pend_err;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("level", level, m_level);
        chk("host_rd_valid", host_rd_valid, cyc == resp_cyc);
        if (cyc == resp_cyc) chk("host_rd_err", host_rd_err, m_err);
        chk("host_rd_data", host_rd_data, m_data);
        chk("overrun", overrun, m_ovr);
        chk("frame_err", frame_err, m_fe);
        chk("timeout", timeout, m_tc == TO);
        chk("irq", irq, (m_level >= THRESH) || (m_tc == TO) || m_ovr);
    endtask

    task automatic drv(input bit v, input logic [7:0] d, input bit fe, input bit req, input bit clr);
        rx_valid = v; rx_data = d; rx_frame_err = fe; host_rd_req = req; clr_status = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 8'h00, 0, 0, 0);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        drv(1, d, 0, 0, 0);
    endtask

    task automatic rd_byte();
        drv(0, 8'h00, 0, 1, 0);
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // reset while the FSM is in READ
        wr_byte(8'h5A);
        drv(0, 8'h00, 0, 1, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(4);

        // basic write/read
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        rd_byte(); rd_byte(); rd_byte();
        idle(2);

        // overrun
        for (int i = 0; i < 4; i++) wr_byte(8'hA0 + 8'(i));
        wr_byte(8'h55);
        for (int i = 0; i < 4; i++) rd_byte();
        drv(0, 8'h00, 0, 0, 1);
        idle(1);

        // write coinciding with fifo_rd_en at level 2
        wr_byte(8'h01); wr_byte(8'h02);
        drv(0, 8'h00, 0, 1, 0);
        wr_byte(8'h77);
        idle(1);
        rd_byte(); rd_byte();
        idle(1);

        // frame error
        drv(1, 8'hAA, 1, 0, 0);
        idle(2);
        drv(0, 8'h00, 0, 0, 1);

        // timeout then empty read
        wr_byte(8'h3C);
        idle(18);
        rd_byte();
        idle(1);
        rd_byte();
        drv(0, 8'h00, 0, 0, 1);
        idle(2);

        // random traffic with occasional reset and status clears
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drv(($urandom_range(0, 2) == 0), 8'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 39) == 0));
            if (($urandom_range(0, 99)) == 0) begin
                rst_n = 1'b1;
                idle(TO + 2);
            end
        end
        rst_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
